// File: rtl/cpu_display_scanner_pkg.sv
// Shared definitions for the debug display scanner: view modes and segment codes.
package cpu_display_pkg;

    typedef enum logic [1:0] {
        MODE_REGS    = 2'd0,
        MODE_INSTR   = 2'd1,
        MODE_PCFLAGS = 2'd2,
        MODE_DASH    = 2'd3
    } mode_t;

    // Segment patterns are {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Entry n is the pattern for hex digit n (entry 15 listed first).
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/cpu_display_scanner_if.sv
// Debug-bus and display signals between the Microcontroller/board and the scanner.
interface cpu_display_scanner_if;
    import cpu_display_pkg::*;

    logic        i_ShowR1;
    logic        i_ShowR2;
    logic [7:0]  i_RegShowing1;
    logic [7:0]  i_RegShowing2;
    logic [7:0]  i_PC;
    logic [15:0] i_INSTR;
    logic        i_Z;
    logic        i_S;
    logic        i_C;
    logic        i_OF;
    mode_t       i_MODE;
    logic [6:0]  o_SEG;
    logic        o_DP;
    logic [3:0]  o_AN;
    logic [3:0]  o_LED;
    logic [1:0]  o_VALID;

    modport master (
        output i_ShowR1, i_ShowR2, i_RegShowing1, i_RegShowing2, i_PC, i_INSTR,
               i_Z, i_S, i_C, i_OF, i_MODE,
        input  o_SEG, o_DP, o_AN, o_LED, o_VALID
    );

    modport slave (
        input  i_ShowR1, i_ShowR2, i_RegShowing1, i_RegShowing2, i_PC, i_INSTR,
               i_Z, i_S, i_C, i_OF, i_MODE,
        output o_SEG, o_DP, o_AN, o_LED, o_VALID
    );

endinterface

// File: rtl/cpu_display_scanner_hex_to_7seg.sv
// Combinational nibble to active-low 7-segment decoder.
module hex_to_7seg
    import cpu_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/cpu_display_scanner.sv
// Captures debug register values and scans them onto a 4-digit 7-segment display.
module cpu_display_scanner
    import cpu_display_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV = 16'd50000
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    cpu_display_scanner_if.slave  bus
);

    logic [7:0]  cap1;
    logic [7:0]  cap2;
    logic [1:0]  valid;
    logic [15:0] cnt;
    logic        tick;
    logic [1:0]  idx;
    logic [1:0]  next_idx;
    logic [3:0]  an_q;
    logic [6:0]  seg_q;
    logic        dp_q;
    logic [3:0]  led_q;
    logic [3:0]  nib;
    logic        use_hex;
    logic [6:0]  special;
    logic        dp_next;
    logic [6:0]  hex_seg;
    logic [6:0]  seg_next;

    // Register capture on show strobes; valid bits stay set until reset.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            cap1  <= '0;
            cap2  <= '0;
            valid <= '0;
        end else begin
            if (bus.i_ShowR1) begin
                cap1     <= bus.i_RegShowing1;
                valid[0] <= 1'b1;
            end
            if (bus.i_ShowR2) begin
                cap2     <= bus.i_RegShowing2;
                valid[1] <= 1'b1;
            end
        end
    end

    assign tick = (cnt == SCAN_DIV - 16'd1);

    // Digit-slot prescaler, wrapping at SCAN_DIV-1.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    assign next_idx = idx + 2'd1;

    // Select the content of the digit that becomes active at the next tick.
    always_comb begin
        nib     = 4'h0;
        use_hex = 1'b1;
        special = SEG_DASH;
        dp_next = 1'b1;
        case (bus.i_MODE)
            MODE_REGS: begin
                case (next_idx)
                    2'd3: begin nib = cap1[7:4]; use_hex = valid[0]; end
                    2'd2: begin nib = cap1[3:0]; use_hex = valid[0]; dp_next = 1'b0; end
                    2'd1: begin nib = cap2[7:4]; use_hex = valid[1]; end
                    default: begin nib = cap2[3:0]; use_hex = valid[1]; end
                endcase
            end
            MODE_INSTR: begin
                case (next_idx)
                    2'd3:    nib = bus.i_INSTR[15:12];
                    2'd2:    nib = bus.i_INSTR[11:8];
                    2'd1:    nib = bus.i_INSTR[7:4];
                    default: nib = bus.i_INSTR[3:0];
                endcase
            end
            MODE_PCFLAGS: begin
                case (next_idx)
                    2'd3:    nib = bus.i_PC[7:4];
                    2'd2:    nib = bus.i_PC[3:0];
                    2'd1:    begin use_hex = 1'b0; special = SEG_BLANK; end
                    default: nib = {bus.i_Z, bus.i_S, bus.i_C, bus.i_OF};
                endcase
            end
            default: use_hex = 1'b0;
        endcase
    end

    hex_to_7seg u_hex (
        .nibble (nib),
        .seg    (hex_seg)
    );

    assign seg_next = use_hex ? hex_seg : special;

    // Advance the digit and load the display outputs only on a tick.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            idx   <= 2'd3;
            an_q  <= 4'hF;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else if (tick) begin
            idx   <= next_idx;
            an_q  <= ~(4'b0001 << next_idx);
            seg_q <= seg_next;
            dp_q  <= dp_next;
        end
    end

    // Flag LEDs follow the ALU flags with one cycle of latency.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            led_q <= '0;
        end else begin
            led_q <= {bus.i_Z, bus.i_S, bus.i_C, bus.i_OF};
        end
    end

    assign bus.o_AN    = an_q;
    assign bus.o_SEG   = seg_q;
    assign bus.o_DP    = dp_q;
    assign bus.o_LED   = led_q;
    assign bus.o_VALID = valid;

endmodule

// File: tb/tb_cpu_display_scanner.sv
// Directed bench for cpu_display_scanner with a short scan period.
module tb_cpu_display_scanner;
    import cpu_display_pkg::*;

    logic i_CLK = 1'b0;
    logic i_RST = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    cpu_display_scanner_if bus ();

    cpu_display_scanner #(.SCAN_DIV(16'd4)) dut (
        .i_CLK (i_CLK),
        .i_RST (i_RST),
        .bus   (bus)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge i_CLK);
        #1;
    endtask

    task automatic chk_digit(input string tag, input logic [3:0] an,
                             input logic [6:0] seg, input logic dp);
        chk({tag, "_an"},  {12'h0, bus.o_AN},  {12'h0, an});
        chk({tag, "_seg"}, {9'h0, bus.o_SEG},  {9'h0, seg});
        chk({tag, "_dp"},  {15'h0, bus.o_DP},  {15'h0, dp});
    endtask

    task automatic chk_reset(input string tag);
        chk_digit(tag, 4'hF, 7'h7F, 1'b1);
        chk({tag, "_led"},   {12'h0, bus.o_LED},   16'h0);
        chk({tag, "_valid"}, {14'h0, bus.o_VALID}, 16'h0);
    endtask

    initial begin
        bus.i_ShowR1      = 1'b0;
        bus.i_ShowR2      = 1'b0;
        bus.i_RegShowing1 = 8'h00;
        bus.i_RegShowing2 = 8'h00;
        bus.i_PC          = 8'h00;
        bus.i_INSTR       = 16'h0000;
        bus.i_Z           = 1'b0;
        bus.i_S           = 1'b0;
        bus.i_C           = 1'b0;
        bus.i_OF          = 1'b0;
        bus.i_MODE        = MODE_REGS;

        #22;
        chk_reset("rst");
        #1 i_RST = 1'b0;

        adv(3);
        chk_digit("pre_tick", 4'hF, 7'h7F, 1'b1);
        adv(1);
        chk_digit("first_tick", 4'hE, 7'h3F, 1'b1);

        // Separate captures of R1 then R2, inside one slot.
        bus.i_ShowR1 = 1'b1; bus.i_RegShowing1 = 8'hA5;
        adv(1);
        bus.i_ShowR1 = 1'b0;
        bus.i_ShowR2 = 1'b1; bus.i_RegShowing2 = 8'h01;
        adv(1);
        bus.i_ShowR2 = 1'b0;
        adv(2);
        chk_digit("r_d1", 4'hD, 7'h40, 1'b1);
        adv(4);
        chk_digit("r_d2", 4'hB, 7'h12, 1'b0);
        adv(4);
        chk_digit("r_d3", 4'h7, 7'h08, 1'b1);
        adv(4);
        chk_digit("r_d0", 4'hE, 7'h79, 1'b1);
        chk("valid", {14'h0, bus.o_VALID}, 16'h3);

        // Simultaneous strobes.
        bus.i_ShowR1 = 1'b1; bus.i_RegShowing1 = 8'h3C;
        bus.i_ShowR2 = 1'b1; bus.i_RegShowing2 = 8'hF0;
        adv(1);
        bus.i_ShowR1 = 1'b0; bus.i_ShowR2 = 1'b0;
        adv(3);
        chk_digit("b_d1", 4'hD, 7'h0E, 1'b1);
        adv(4);
        chk_digit("b_d2", 4'hB, 7'h46, 1'b0);
        adv(4);
        chk_digit("b_d3", 4'h7, 7'h30, 1'b1);
        adv(4);
        chk_digit("b_d0", 4'hE, 7'h40, 1'b1);

        // Instruction view.
        bus.i_MODE  = MODE_INSTR;
        bus.i_INSTR = 16'h0105;
        adv(4);
        chk_digit("i_d1", 4'hD, 7'h40, 1'b1);
        adv(4);
        chk_digit("i_d2", 4'hB, 7'h79, 1'b1);
        adv(4);
        chk_digit("i_d3", 4'h7, 7'h40, 1'b1);
        adv(4);
        chk_digit("i_d0", 4'hE, 7'h12, 1'b1);

        // Switch to PC/flags view mid-slot; old digit must hold.
        adv(2);
        bus.i_MODE = MODE_PCFLAGS;
        bus.i_PC   = 8'h1F;
        bus.i_Z    = 1'b1;
        bus.i_C    = 1'b1;
        chk("led_pre", {12'h0, bus.o_LED}, 16'h0);
        adv(1);
        chk_digit("hold", 4'hE, 7'h12, 1'b1);
        chk("led", {12'h0, bus.o_LED}, 16'hA);
        adv(1);
        chk_digit("p_d1", 4'hD, 7'h7F, 1'b1);
        adv(4);
        chk_digit("p_d2", 4'hB, 7'h0E, 1'b1);
        adv(4);
        chk_digit("p_d3", 4'h7, 7'h79, 1'b1);
        adv(4);
        chk_digit("p_d0", 4'hE, 7'h08, 1'b1);

        // Dash view.
        bus.i_MODE = MODE_DASH;
        adv(4);
        chk_digit("dash_d1", 4'hD, 7'h3F, 1'b1);

        // Asynchronous reset mid-slot, checked before the next edge.
        adv(2);
        i_RST = 1'b1;
        #2;
        chk_reset("mid_rst");
        bus.i_MODE = MODE_REGS;
        #2 i_RST = 1'b0;
        adv(3);
        chk_digit("post_pre", 4'hF, 7'h7F, 1'b1);
        adv(1);
        chk_digit("post_tick", 4'hE, 7'h3F, 1'b1);
        chk("post_valid", {14'h0, bus.o_VALID}, 16'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
